// File: rtl/ps2_key_receiver_pkg.sv
// Shared PS/2 scancode constants, frame FSM state type and key_event layout.
// Also holds the main-row digit decoder used on the FIFO head.
package ps2_key_receiver_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_DIG0 = 8'h45;
  localparam logic [7:0] SC_DIG1 = 8'h16;
  localparam logic [7:0] SC_DIG2 = 8'h1E;
  localparam logic [7:0] SC_DIG3 = 8'h26;
  localparam logic [7:0] SC_DIG4 = 8'h25;
  localparam logic [7:0] SC_DIG5 = 8'h2E;
  localparam logic [7:0] SC_DIG6 = 8'h36;
  localparam logic [7:0] SC_DIG7 = 8'h3D;
  localparam logic [7:0] SC_DIG8 = 8'h3E;
  localparam logic [7:0] SC_DIG9 = 8'h46;

  localparam int unsigned KE_CODE_LSB = 0;
  localparam int unsigned KE_EXT_BIT  = 8;
  localparam int unsigned KE_BRK_BIT  = 9;
  localparam int unsigned KE_WIDTH    = 10;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } frame_state_e;

  // Returns {valid, digit}; digit is 0 when the code is not a main-row digit.
  function automatic logic [4:0] decode_digit(input logic [7:0] code);
    logic [4:0] res;
    res = 5'd0;
    case (code)
      SC_DIG0: res = {1'b1, 4'd0};
      SC_DIG1: res = {1'b1, 4'd1};
      SC_DIG2: res = {1'b1, 4'd2};
      SC_DIG3: res = {1'b1, 4'd3};
      SC_DIG4: res = {1'b1, 4'd4};
      SC_DIG5: res = {1'b1, 4'd5};
      SC_DIG6: res = {1'b1, 4'd6};
      SC_DIG7: res = {1'b1, 4'd7};
      SC_DIG8: res = {1'b1, 4'd8};
      SC_DIG9: res = {1'b1, 4'd9};
      default: res = 5'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO for key events; Depth must be a power of two >= 2.
// A push while full is only accepted when a real pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             pop_eff, push_eff;

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);
  assign data_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_eff) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: line conditioning, 11-bit frame deserialiser,
// E0/F0 prefix folding and an FWFT event FIFO with digit decode on the head.
module ps2_key_receiver
  import ps2_key_receiver_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 100000,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                CLK_50,
  input  logic                reset_en,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  input  logic                rd_en,
  output logic [KE_WIDTH-1:0] key_event,
  output logic                digit_valid,
  output logic [3:0]          digit,
  output logic                empty,
  output logic                overflow,
  output logic                frame_err
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);

  logic [1:0]          clk_sync_q, data_sync_q;
  logic [FCW-1:0]      fcnt_q;
  logic                filt_q, filt_prev_q;
  logic                strobe, data_s;
  frame_state_e        state_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          shift_q;
  logic                parity_q;
  logic [TCW-1:0]      tmo_q;
  logic                ext_q, brk_q;
  logic                push_q;
  logic [KE_WIDTH-1:0] push_data_q;
  logic                frame_err_q, overflow_q;
  logic                fifo_full;
  logic [4:0]          dec;

  assign data_s = data_sync_q[1];
  assign strobe = filt_prev_q & ~filt_q;

  // Lines idle high, so the conditioning chain resets high to avoid a false strobe.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      fcnt_q      <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_prev_q <= filt_q;
      if (clk_sync_q[1] == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_q <= clk_sync_q[1];
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (strobe) begin
            if (!data_s) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end
          end
        end
        StData: begin
          if (strobe) begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
        end
        StParity: begin
          if (strobe) begin
            parity_q <= data_s;
            state_q  <= StStop;
          end
        end
        StStop: begin
          if (strobe) begin
            state_q <= StIdle;
            if (data_s && (^{shift_q, parity_q})) begin
              if (shift_q == SC_EXT) begin
                ext_q <= 1'b1;
              end else if (shift_q == SC_BRK) begin
                brk_q <= 1'b1;
              end else begin
                push_q      <= 1'b1;
                push_data_q <= {brk_q, ext_q, shift_q};
                ext_q       <= 1'b0;
                brk_q       <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      // Abort a stalled partial frame; overrides the state update above.
      if (state_q != StIdle && !strobe) begin
        if (tmo_q == TCW'(TIMEOUT - 1)) begin
          state_q     <= StIdle;
          frame_err_q <= 1'b1;
          ext_q       <= 1'b0;
          brk_q       <= 1'b0;
          tmo_q       <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      overflow_q <= 1'b0;
    end else if (push_q && fifo_full && !(rd_en && !empty)) begin
      overflow_q <= 1'b1;
    end
  end

  ps2_event_fifo #(
    .Width(KE_WIDTH),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (CLK_50),
    .rst_ni (reset_en),
    .push_i (push_q),
    .data_i (push_data_q),
    .pop_i  (rd_en),
    .data_o (key_event),
    .full_o (fifo_full),
    .empty_o(empty)
  );

  assign dec         = decode_digit(key_event[KE_CODE_LSB +: 8]);
  assign digit_valid = ~empty & ~key_event[KE_EXT_BIT] & dec[4];
  assign digit       = digit_valid ? dec[3:0] : 4'd0;
  assign overflow    = overflow_q;
  assign frame_err   = frame_err_q;

endmodule
